// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register arbiter: FSM state encoding, owner
// index width and the round-robin winner search.
package reg_arb_pkg;

  localparam int OWNER_W = 3;  // owner index width, covers up to 8 requesters
  localparam int MAX_REQ = 8;  // widest requester vector the arbiter supports
  localparam int CNT_W   = 8;  // lock counter width, covers MAX_LOCK up to 255

  typedef logic [OWNER_W-1:0] owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  // Returns the first set bit of r searching upward from (ptr+1) mod n,
  // wrapping around. The descending scan lets the nearest candidate win.
  // The result is don't-care when r has no bit set in [n-1:0].
  function automatic owner_t rr_pick(input logic [MAX_REQ-1:0] r,
                                     input int n,
                                     input owner_t ptr);
    owner_t pick;
    int     idx;
    pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (r[idx[OWNER_W-1:0]]) pick = idx[OWNER_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/reg_arbiter_share_reg.sv
// share_reg: WIDTH-bit shared register with write enable.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset, clears q and beats we
//   we  - write enable
//   d   - write data
//   q   - register contents
module share_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin arbiter guarding one shared register. A granted
// requester writes its data slice into the register every cycle it holds
// the grant; it may keep ownership with lock for up to MAX_LOCK cycles.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   req      - per-requester write request (level)
//   lock     - per-requester request to keep ownership after a grant
//   din      - write data, requester i on [i*WIDTH +: WIDTH]
//   gnt      - registered one-hot (or zero) grant
//   q        - shared register contents
//   owner    - index of the last granted requester
//   wr_pulse - high the cycle after each register write
//   busy     - high while a tenure is in progress
import reg_arb_pkg::*;

module reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [OWNER_W-1:0]     owner,
  output logic                   wr_pulse,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);
  // With MAX_LOCK == 1 a single granted cycle is already the whole tenure.
  localparam logic             CAN_LOCK = (MAX_LOCK > 1);

  arb_state_t       state;
  owner_t           rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] lock_ext;
  owner_t             win;
  logic               hold;
  logic               we;
  logic [WIDTH-1:0]   wdata;

  // Widen the requester vectors so owner can index them at full width.
  always_comb begin
    req_ext             = '0;
    req_ext[N_REQ-1:0]  = req;
    lock_ext            = '0;
    lock_ext[N_REQ-1:0] = lock;
  end

  assign win  = rr_pick(req_ext, N_REQ, rr_ptr);
  assign hold = req_ext[owner] & lock_ext[owner];

  // The write is tied to the registered grant alone, so a request that
  // falls on the grant edge still gets its write.
  assign we = |gnt;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) wdata = din[i*WIDTH +: WIDTH];
    end
  end

  share_reg #(
    .WIDTH(WIDTH)
  ) u_share_reg (
    .clk(clk),
    .rst(rst),
    .we (we),
    .d  (wdata),
    .q  (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      wr_pulse <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      rr_ptr   <= owner_t'(N_REQ - 1);
    end else begin
      wr_pulse <= we;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt   <= N_REQ'(1) << win;
            owner <= win;
            busy  <= 1'b1;
            state <= ST_GRANT;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (hold && CAN_LOCK) begin
            cnt   <= CNT_W'(1);
            state <= ST_LOCKED;
          end else begin
            // rr_ptr = owner puts the finished requester last in line.
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= owner;
            state  <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (!hold || (cnt >= CNT_LAST)) begin
            gnt    <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
            rr_ptr <= owner;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// Testbench for reg_arbiter: directed scenarios plus a randomized run
// against a tenure-level reference model.
module tb_reg_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_LOCK = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] din;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic [2:0]             owner;
  logic                   wr_pulse;
  logic                   busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current holder (-1 none), cycles held so far,
  // last tenure owner, register value, last granted index, write flag.
  int               m_h;
  int               m_r;
  int               m_last;
  int               m_owner;
  logic [WIDTH-1:0] m_q;
  logic             m_wr;

  always #5 clk = ~clk;

  reg_arbiter #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .lock(lock),
    .din(din),
    .gnt(gnt),
    .q(q),
    .owner(owner),
    .wr_pulse(wr_pulse),
    .busy(busy)
  );

  function automatic logic [N_REQ-1:0] m_gnt();
    if (m_h < 0) return '0;
    return N_REQ'(1) << m_h;
  endfunction

  // Advance the model by one edge using the current inputs, then step the
  // clock and settle past the edge.
  task automatic tick();
    if (rst) begin
      m_h = -1; m_r = 0; m_last = N_REQ - 1; m_owner = 0; m_q = '0; m_wr = 1'b0;
    end else begin
      m_wr = (m_h >= 0);
      if (m_h >= 0) begin
        m_q = din[m_h*WIDTH +: WIDTH];
        if (lock[m_h] && req[m_h] && m_r < MAX_LOCK) m_r++;
        else begin m_last = m_h; m_h = -1; end
      end else if (req != '0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          int idx;
          idx = (m_last + k) % N_REQ;
          if (req[idx]) begin m_h = idx; m_r = 1; m_owner = idx; break; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; din = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = N_REQ'($urandom); lock = N_REQ'($urandom); din = (N_REQ*WIDTH)'($urandom);
    tick(); tick();
    n_cmp++; if (gnt !== '0)      begin n_bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_cmp++; if (q !== '0)        begin n_bad++; $display("FAIL reset_q: got %h want 0", q); end
    n_cmp++; if (owner !== 3'd0)  begin n_bad++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_cmp++; if (wr_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", wr_pulse); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; req = '0; lock = '0;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0001; din[7:0] = 8'hA5;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    req = '0;  // drop on the grant edge: write must still happen
    tick();
    n_cmp++; if (q !== 8'hA5)       begin n_bad++; $display("FAIL single_q: got %h want a5", q); end
    n_cmp++; if (owner !== 3'd0)    begin n_bad++; $display("FAIL single_owner: got %0d want 0", owner); end
    n_cmp++; if (wr_pulse !== 1'b1) begin n_bad++; $display("FAIL single_wr: got %b want 1", wr_pulse); end
    n_cmp++; if (gnt !== 4'b0000)   begin n_bad++; $display("FAIL single_gnt_drop: got %b want 0000", gnt); end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] exp;
    do_reset();
    req = 4'b1111; lock = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = (c % 2 == 1) ? (N_REQ'(1) << (((c - 1) / 2) % N_REQ)) : '0;
      n_cmp++;
      if (gnt !== exp) begin n_bad++; $display("FAIL rr_cycle%0d: got %b want %b", c, gnt, exp); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_lock_timeout();
    int held;
    int waited;
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    held = 0;
    tick();
    while (gnt === 4'b0001 && held < 20) begin held++; tick(); end
    n_cmp++; if (held != MAX_LOCK) begin n_bad++; $display("FAIL lock_len: got %0d want %0d", held, MAX_LOCK); end
    waited = 0;
    while (gnt === 4'b0000 && waited < 4) begin waited++; tick(); end
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL lock_next: got %b want 0010", gnt); end
    n_cmp++; if (waited != 1)     begin n_bad++; $display("FAIL lock_gap: got %0d want 1", waited); end
    req = '0; lock = '0;
    tick(); tick();
  endtask

  task automatic test_lock_drop();
    do_reset();
    req = 4'b0100; lock = 4'b0100; din[23:16] = 8'h5A;
    tick(); tick(); tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL drop_locked: got %b want 0100", gnt); end
    lock = 4'b0000;
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL drop_gnt: got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL drop_busy: got %b want 0", busy); end
    n_cmp++; if (q !== 8'h5A)     begin n_bad++; $display("FAIL drop_q: got %h want 5a", q); end
    req = '0; din[23:16] = 8'h11;
    tick(); tick();
    n_cmp++; if (q !== 8'h5A)     begin n_bad++; $display("FAIL drop_q_hold: got %h want 5a", q); end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    req = 4'b0010; lock = 4'b0010; din[15:8] = 8'h42;
    tick(); tick(); tick();
    n_cmp++; if (q !== 8'h42) begin n_bad++; $display("FAIL rstlk_pre_q: got %h want 42", q); end
    rst = 1'b1; din[15:8] = 8'hEE;
    tick();
    n_cmp++; if (q !== 8'h00)      begin n_bad++; $display("FAIL rstlk_q: got %h want 00", q); end
    n_cmp++; if (gnt !== 4'b0000)  begin n_bad++; $display("FAIL rstlk_gnt: got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rstlk_busy: got %b want 0", busy); end
    n_cmp++; if (wr_pulse !== 1'b0) begin n_bad++; $display("FAIL rstlk_wr: got %b want 0", wr_pulse); end
    rst = 1'b0; req = '0; lock = '0;
    tick();
    n_cmp++; if (q !== 8'h00)      begin n_bad++; $display("FAIL rstlk_stale: got %h want 00", q); end
  endtask

  task automatic test_nonowner_ignored();
    int waited;
    do_reset();
    req = 4'b0010; lock = 4'b0010; din[15:8] = 8'h11; din[31:24] = 8'h3C;
    tick();
    req = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if (q === 8'h3C)     begin n_bad++; $display("FAIL nonown_q%0d: got %h want not 3c", c, q); end
      n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL nonown_gnt%0d: got %b want 0010", c, gnt); end
    end
    lock = 4'b0000; req = 4'b1000;
    tick();
    waited = 0;
    while (gnt !== 4'b1000 && waited < 4) begin waited++; tick(); end
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL nonown_later_gnt: got %b want 1000", gnt); end
    req = '0;
    tick();
    n_cmp++; if (q !== 8'h3C) begin n_bad++; $display("FAIL nonown_later_q: got %h want 3c", q); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int b = 0; b < N_REQ; b++) begin
        if ($urandom_range(0, 3) == 0) req[b]  = ~req[b];
        if ($urandom_range(0, 7) == 0) lock[b] = ~lock[b];
        din[b*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      tick();
      n_cmp++; if (gnt !== m_gnt())        begin n_bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, gnt, m_gnt()); end
      n_cmp++; if (q !== m_q)              begin n_bad++; $display("FAIL rnd_q@%0d: got %h want %h", c, q, m_q); end
      n_cmp++; if (owner !== 3'(m_owner))  begin n_bad++; $display("FAIL rnd_owner@%0d: got %0d want %0d", c, owner, m_owner); end
      n_cmp++; if (wr_pulse !== m_wr)      begin n_bad++; $display("FAIL rnd_wr@%0d: got %b want %b", c, wr_pulse, m_wr); end
      n_cmp++; if (busy !== (m_h >= 0))    begin n_bad++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, (m_h >= 0)); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; din = '0;
    m_h = -1; m_r = 0; m_last = N_REQ - 1; m_owner = 0; m_q = '0; m_wr = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock_timeout();
    test_lock_drop();
    test_reset_mid_lock();
    test_nonowner_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the shared register data width.
REQ-003 The block SHALL have parameter MAX_LOCK, default 8, giving the maximum consecutive granted cycles per locked tenure (1..255).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-006 The block SHALL have port req, input, N_REQ, per-requester write request, level, held until granted.
REQ-007 The block SHALL have port lock, input, N_REQ, per-requester request to keep ownership after a grant.
REQ-008 The block SHALL have port din, input, N_REQ*WIDTH, write data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port gnt, output, N_REQ, one-hot or zero grant, registered.
REQ-010 The block SHALL have port q, output, WIDTH, shared register contents.
REQ-011 The block SHALL have port owner, output, 3, index of the last granted requester.
REQ-012 The block SHALL have port wr_pulse, output, 1, high for one cycle after each cycle in which q was written.
REQ-013 The block SHALL have port busy, output, 1, high while the FSM is in GRANT or LOCKED.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT and LOCKED.
REQ-015 In IDLE with any req bit high, the block SHALL choose a winner round-robin, starting at (rr_ptr+1) mod N_REQ, assert only that gnt bit next cycle and enter GRANT.
REQ-016 In IDLE with req all zero, gnt SHALL be zero and state SHALL remain IDLE.
REQ-017 In every cycle with gnt[i] high, q SHALL load din slice i at that clock edge, owner SHALL become i and wr_pulse SHALL be high the following cycle.
REQ-018 The arbitration latency from req rising in IDLE to gnt SHALL be exactly one cycle.
REQ-019 From GRANT, if lock[owner] and req[owner] are high, the block SHALL enter LOCKED, keep gnt[owner] high and load the lock counter with 1.
REQ-020 From GRANT otherwise, the block SHALL drop gnt, set rr_ptr to owner and return to IDLE, so at most one grant is issued every two cycles.
REQ-021 In LOCKED the counter SHALL increment each granted cycle, and the block SHALL leave to IDLE (gnt dropped, rr_ptr=owner) when lock[owner] or req[owner] falls or the counter reaches MAX_LOCK-1.
REQ-022 A requester whose tenure ended by MAX_LOCK timeout SHALL NOT win the next arbitration if any other req bit is high.
REQ-023 Requests from non-owners during GRANT or LOCKED SHALL be ignored and SHALL NOT alter q.
REQ-024 A req drop on the same edge as its grant SHALL NOT cancel that write; the write occurs and the FSM proceeds per REQ-020.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL set state to IDLE, gnt=0, q=0, owner=0, wr_pulse=0, busy=0, counter=0 and rr_ptr=N_REQ-1, overriding all other events.
REQ-026 Reset asserted mid-GRANT or mid-LOCKED SHALL abort the tenure with no write on that edge.

Structure
REQ-027 The FSM state encoding and the owner width constant (3) SHALL be defined in a shared package, reg_arb_pkg.
REQ-028 The shared register SHALL be a separate sub-module, share_reg, a WIDTH-bit register with synchronous reset and write enable.

Verification
REQ-029 Reset then req=4'b0001, din[7:0]=8'hA5 -> gnt=4'b0001 next cycle, q=8'hA5, owner=0, wr_pulse following cycle.
REQ-030 req=4'b1111 held, lock=0, from reset -> grant order 0,1,2,3,0, each gnt one cycle with one idle cycle between.
REQ-031 req=4'b0011, lock=4'b0001, MAX_LOCK=8 -> gnt[0] high for exactly 8 cycles, then gnt[1] granted next arbitration.
REQ-032 In LOCKED for requester 2, drop lock[2] -> gnt drops at the next edge, state IDLE, q retains the last written value.
REQ-033 rst pulsed during LOCKED with din changing -> q=0, gnt=0, busy=0 next cycle, and no stale write.
REQ-034 req[3] high alone while requester 1 is locked, din3=8'h3C -> q never equals 8'h3C until requester 1's tenure ends.
